// File: rtl/seg_display_driver.sv
// seg_display_driver
//   Latches a 16-bit two's-complement accumulator value on a load strobe and
//   shows it on an 8-digit, time-multiplexed seven-segment display, either as
//   4-digit hex or as signed decimal. The decimal digits come from a
//   sequential double-dabble converter that takes 16 cycles.
//
// Ports
//   clk   : system clock, rising edge
//   btnu  : asynchronous active-high reset
//   value : two's-complement value to display
//   load  : capture strobe (ignored while busy)
//   mode  : 0 = hex, 1 = signed decimal; sampled only with load
//   an    : digit enables, active-low, an[0] = rightmost digit
//   seg   : segments {g,f,e,d,c,b,a}, active-low
//   dp    : decimal point, active-low, always off
//   busy  : high from the capture edge until the display commit edge
//
// Handshake: a load pulse is accepted only on an edge where busy is low;
// any load seen while busy is high is dropped, never queued.
module seg_display_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        btnu,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        mode,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] MINUS = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [15:0] hex_val;
  logic [15:0] mag_sr;
  logic [19:0] bcd;
  logic [19:0] bcd_adj;
  logic [3:0]  step_cnt;
  logic        mode_q;
  logic        neg_q;

  logic [6:0]  disp_seg [8];
  logic        disp_on  [8];
  logic [6:0]  new_seg  [8];
  logic        new_on   [8];

  logic [CW-1:0] scan_cnt;
  logic [2:0]    digit_idx;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign dp   = 1'b1;
  assign busy = (state != IDLE);

  // FSM state register
  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) state <= IDLE;
    else      state <= state_next;
  end

  // FSM next state: CONV runs step_cnt 0..15, i.e. exactly 16 edges
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = CONV;
      CONV:    if (step_cnt == 4'd15) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Double-dabble correction: add 3 to every BCD nibble >= 5 before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Display image built from the captured value, committed in DONE
  always_comb begin
    logic nz;
    nz = 1'b0;
    for (int i = 0; i < 8; i++) begin
      new_seg[i] = BLANK;
      new_on[i]  = 1'b0;
    end
    if (!mode_q) begin
      for (int i = 0; i < 4; i++) begin
        new_on[i]  = 1'b1;
        new_seg[i] = hex7(hex_val[4*i +: 4]);
      end
    end else begin
      // Leading-zero blanking from the top nibble down; digit 0 always lit
      for (int i = 4; i >= 0; i--) begin
        if (bcd[4*i +: 4] != 4'd0 || i == 0) nz = 1'b1;
        new_on[i]  = nz;
        new_seg[i] = nz ? hex7(bcd[4*i +: 4]) : BLANK;
      end
      new_on[5]  = neg_q;
      new_seg[5] = neg_q ? MINUS : BLANK;
    end
  end

  // Capture, conversion datapath and display registers
  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      hex_val  <= '0;
      mag_sr   <= '0;
      bcd      <= '0;
      step_cnt <= '0;
      mode_q   <= 1'b0;
      neg_q    <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        disp_seg[i] <= (i == 0) ? 7'b1000000 : BLANK;
        disp_on[i]  <= (i == 0);
      end
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            hex_val  <= value;
            // -32768 negates to itself, which read as unsigned is 32768
            mag_sr   <= value[15] ? (~value + 16'd1) : value;
            mode_q   <= mode;
            neg_q    <= value[15] & mode;
            bcd      <= '0;
            step_cnt <= '0;
          end
        end
        CONV: begin
          bcd      <= {bcd_adj[18:0], mag_sr[15]};
          mag_sr   <= {mag_sr[14:0], 1'b0};
          step_cnt <= step_cnt + 4'd1;
        end
        DONE: begin
          for (int i = 0; i < 8; i++) begin
            disp_seg[i] <= new_seg[i];
            disp_on[i]  <= new_on[i];
          end
        end
        default: ;
      endcase
    end
  end

  // Free-running scan; outputs registered one cycle behind the index
  always_ff @(posedge clk or posedge btnu) begin
    if (btnu) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      an        <= 8'hFF;
      seg       <= BLANK;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + CW'(1);
      end
      an  <= disp_on[digit_idx] ? ~(8'd1 << digit_idx) : 8'hFF;
      seg <= disp_on[digit_idx] ? disp_seg[digit_idx] : BLANK;
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
module tb_seg_display_driver;

  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D6 = 7'b0000010;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000;
  localparam logic [6:0] D9 = 7'b0010000;
  localparam logic [6:0] DA = 7'b0001000;
  localparam logic [6:0] DF = 7'b0001110;
  localparam logic [6:0] DM = 7'b0111111;

  logic        clk = 1'b0;
  logic        btnu = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] seen_on;
  logic [6:0] seen_seg [8];
  int         obs_bad;
  int         obs_busy;
  int         bc;

  seg_display_driver #(.REFRESH_DIV(4)) dut (
    .clk(clk), .btnu(btnu), .value(value), .load(load), .mode(mode),
    .an(an), .seg(seg), .dp(dp), .busy(busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic load_value(input logic [15:0] v, input logic m, output int cycles);
    @(negedge clk);
    value = v; mode = m; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) cycles++;
      else break;
      @(negedge clk);
    end
  endtask

  task automatic observe(input int n);
    seen_on  = '0;
    obs_bad  = 0;
    obs_busy = 0;
    for (int d = 0; d < 8; d++) seen_seg[d] = 7'h7F;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (dp !== 1'b1) obs_bad++;
      if (busy !== 1'b0) obs_busy++;
      if (an === 8'hFF) begin
        if (seg !== 7'h7F) obs_bad++;
      end else if ($countones(~an) != 1) begin
        obs_bad++;
      end else begin
        for (int d = 0; d < 8; d++) begin
          if (an[d] == 1'b0) begin
            if (seen_on[d] && seen_seg[d] !== seg) obs_bad++;
            seen_on[d]  = 1'b1;
            seen_seg[d] = seg;
          end
        end
      end
    end
  endtask

  // scenarios
  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_an: got %b want 11111111", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %b want 1111111", seg); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    btnu = 1'b0;
    observe(40);
    checks++; if (seen_on !== 8'h01) begin errors++; $display("FAIL idle_mask: got %b want 00000001", seen_on); end
    checks++; if (seen_seg[0] !== D0) begin errors++; $display("FAIL idle_d0: got %b want %b", seen_seg[0], D0); end
    checks++; if (obs_busy != 0) begin errors++; $display("FAIL idle_busy: got %0d busy samples want 0", obs_busy); end
    checks++; if (obs_bad != 0) begin errors++; $display("FAIL idle_scan: got %0d bad samples want 0", obs_bad); end
  endtask

  task automatic test_hex;
    load_value(16'h1A2F, 1'b0, bc);
    checks++; if (bc != 17) begin errors++; $display("FAIL hex_busy_len: got %0d want 17", bc); end
    repeat (2) @(negedge clk);
    observe(34);
    checks++; if (seen_on !== 8'h0F) begin errors++; $display("FAIL hex_mask: got %b want 00001111", seen_on); end
    checks++; if (seen_seg[3] !== D1) begin errors++; $display("FAIL hex_d3: got %b want %b", seen_seg[3], D1); end
    checks++; if (seen_seg[2] !== DA) begin errors++; $display("FAIL hex_d2: got %b want %b", seen_seg[2], DA); end
    checks++; if (seen_seg[1] !== D2) begin errors++; $display("FAIL hex_d1: got %b want %b", seen_seg[1], D2); end
    checks++; if (seen_seg[0] !== DF) begin errors++; $display("FAIL hex_d0: got %b want %b", seen_seg[0], DF); end
    checks++; if (obs_bad != 0) begin errors++; $display("FAIL hex_scan: got %0d bad samples want 0", obs_bad); end
  endtask

  task automatic test_dec_neg;
    load_value(16'hFF85, 1'b1, bc);
    checks++; if (bc != 17) begin errors++; $display("FAIL dec_busy_len: got %0d want 17", bc); end
    repeat (2) @(negedge clk);
    observe(34);
    checks++; if (seen_on !== 8'h27) begin errors++; $display("FAIL dec_mask: got %b want 00100111", seen_on); end
    checks++; if (seen_seg[5] !== DM) begin errors++; $display("FAIL dec_sign: got %b want %b", seen_seg[5], DM); end
    checks++; if (seen_seg[2] !== D1) begin errors++; $display("FAIL dec_d2: got %b want %b", seen_seg[2], D1); end
    checks++; if (seen_seg[1] !== D2) begin errors++; $display("FAIL dec_d1: got %b want %b", seen_seg[1], D2); end
    checks++; if (seen_seg[0] !== D3) begin errors++; $display("FAIL dec_d0: got %b want %b", seen_seg[0], D3); end
    checks++; if (obs_bad != 0) begin errors++; $display("FAIL dec_scan: got %0d bad samples want 0", obs_bad); end
  endtask

  task automatic test_min_value;
    load_value(16'h8000, 1'b1, bc);
    repeat (2) @(negedge clk);
    observe(34);
    checks++; if (seen_on !== 8'h3F) begin errors++; $display("FAIL min_dec_mask: got %b want 00111111", seen_on); end
    checks++; if (seen_seg[5] !== DM) begin errors++; $display("FAIL min_dec_sign: got %b want %b", seen_seg[5], DM); end
    checks++; if (seen_seg[4] !== D3) begin errors++; $display("FAIL min_dec_d4: got %b want %b", seen_seg[4], D3); end
    checks++; if (seen_seg[3] !== D2) begin errors++; $display("FAIL min_dec_d3: got %b want %b", seen_seg[3], D2); end
    checks++; if (seen_seg[2] !== D7) begin errors++; $display("FAIL min_dec_d2: got %b want %b", seen_seg[2], D7); end
    checks++; if (seen_seg[1] !== D6) begin errors++; $display("FAIL min_dec_d1: got %b want %b", seen_seg[1], D6); end
    checks++; if (seen_seg[0] !== D8) begin errors++; $display("FAIL min_dec_d0: got %b want %b", seen_seg[0], D8); end
    load_value(16'h8000, 1'b0, bc);
    repeat (2) @(negedge clk);
    mode = 1'b1;  // mode change without load must not matter
    observe(34);
    checks++; if (seen_on !== 8'h0F) begin errors++; $display("FAIL min_hex_mask: got %b want 00001111", seen_on); end
    checks++; if (seen_seg[3] !== D8) begin errors++; $display("FAIL min_hex_d3: got %b want %b", seen_seg[3], D8); end
    checks++; if (seen_seg[2] !== D0 || seen_seg[1] !== D0 || seen_seg[0] !== D0) begin
      errors++; $display("FAIL min_hex_low: got %b %b %b want %b x3", seen_seg[2], seen_seg[1], seen_seg[0], D0);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    value = 16'd5; mode = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    value = 16'd9; load = 1'b1;  // arrives mid-conversion: must be dropped
    @(negedge clk);
    load = 1'b0;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      bc++;
      @(negedge clk);
    end
    checks++; if (bc >= 40) begin errors++; $display("FAIL b2b_busy_timeout: got %0d cycles want <40", bc); end
    repeat (2) @(negedge clk);
    observe(34);
    checks++; if (seen_on !== 8'h01) begin errors++; $display("FAIL b2b_mask: got %b want 00000001", seen_on); end
    checks++; if (seen_seg[0] !== D5) begin errors++; $display("FAIL b2b_d0: got %b want %b", seen_seg[0], D5); end
    checks++; if (obs_busy != 0) begin errors++; $display("FAIL b2b_requeued: got %0d busy samples want 0", obs_busy); end
    load_value(16'd9, 1'b1, bc);
    repeat (2) @(negedge clk);
    observe(34);
    checks++; if (seen_on !== 8'h01) begin errors++; $display("FAIL reload_mask: got %b want 00000001", seen_on); end
    checks++; if (seen_seg[0] !== D9) begin errors++; $display("FAIL reload_d0: got %b want %b", seen_seg[0], D9); end
  endtask

  task automatic test_reset_mid_conv;
    @(negedge clk);
    value = 16'd4660; mode = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (7) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
    btnu = 1'b1;
    #1;
    checks++; if (an !== 8'hFF) begin errors++; $display("FAIL abort_an: got %b want 11111111", an); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    @(negedge clk);
    btnu = 1'b0;
    repeat (25) @(negedge clk);
    observe(34);
    checks++; if (seen_on !== 8'h01) begin errors++; $display("FAIL abort_mask: got %b want 00000001", seen_on); end
    checks++; if (seen_seg[0] !== D0) begin errors++; $display("FAIL abort_d0: got %b want %b", seen_seg[0], D0); end
    checks++; if (obs_busy != 0) begin errors++; $display("FAIL abort_busy_after: got %0d busy samples want 0", obs_busy); end
  endtask

  // sequence + final report
  initial begin
    test_reset();
    test_hex();
    test_dec_neg();
    test_min_value();
    test_back_to_back();
    test_reset_mid_conv();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
